// File: rtl/cascade_time_counter_if.sv
// Control and data bundle for cascade_time_counter: counting controls in, digit bus and flags out.
interface cascade_time_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic              en;
  logic              up;
  logic              hold_at_end;
  logic              load;
  logic [DIGITS*4-1:0] load_val;
  logic [DIGITS*4-1:0] count;
  logic              tc;
  logic              wrap;

  modport master (
    output en, up, hold_at_end, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up, hold_at_end, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/cascade_time_counter.sv
// Multi-digit cascaded time counter: per-digit maxima, single-cycle carry/borrow ripple,
// clamped load, wrap or hold at the terminal value.
module cascade_time_counter #(
  parameter int unsigned         DIGITS    = 4,
  parameter logic [DIGITS*4-1:0] DIGIT_MAX = 16'h5959
) (
  input logic                   clk,
  input logic                   rst,
  cascade_time_counter_if.slave bus
);

  localparam int unsigned W = DIGITS * 4;

  logic [W-1:0]      count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] term;
  logic              all_term;
  logic              carry;

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] mx,
                                            input logic up);
    if (up) return (d == mx) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? mx : d - 4'd1;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Terminal value per digit depends on the live direction input.
  always_comb begin
    term = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      term[i] = bus.up ? (count_q[i*4 +: 4] == DIGIT_MAX[i*4 +: 4])
                       : (count_q[i*4 +: 4] == 4'd0);
    end
    all_term = &term;
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    if (bus.load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        count_d[i*4 +: 4] = clamp_digit(bus.load_val[i*4 +: 4], DIGIT_MAX[i*4 +: 4]);
      end
    end else if (bus.en && !(all_term && bus.hold_at_end)) begin
      // With every digit terminal the ripple steps all of them: that is the full-range wrap.
      wrap_d = all_term;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (carry) begin
          count_d[i*4 +: 4] = step_digit(count_q[i*4 +: 4], DIGIT_MAX[i*4 +: 4], bus.up);
        end
        carry = carry & term[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = all_term;

endmodule
